// File: rtl/bfm_apb_master_arbiter.sv
// Round-robin arbiter that replays one requester's APB transfer at a time on the
// bridge master port, with a watchdog that aborts transfers the bridge never completes.
module bfm_apb_master_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic                 PCLK_PM,
  input  logic                 PRESETN_PM,
  input  logic [NREQ-1:0]      REQ_PSEL,
  input  logic [NREQ-1:0]      REQ_PENABLE,
  input  logic [NREQ-1:0]      REQ_PWRITE,
  input  logic [32*NREQ-1:0]   REQ_PADDR,
  input  logic [32*NREQ-1:0]   REQ_PWDATA,
  output logic [31:0]          REQ_PRDATA,
  output logic [NREQ-1:0]      REQ_PREADY,
  output logic [NREQ-1:0]      REQ_PSLVERR,
  output logic [31:0]          PADDR_PM,
  output logic                 PWRITE_PM,
  output logic                 PENABLE_PM,
  output logic [31:0]          PWDATA_PM,
  input  logic [31:0]          PRDATA_PM,
  input  logic                 PREADY_PM,
  input  logic                 PSLVERR_PM,
  output logic [NREQ-1:0]      GRANT,
  output logic                 TIMEOUT_ERR
);

  localparam int unsigned DW = 32;
  localparam int unsigned IW = (NREQ > 2) ? 2 : 1;
  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DONE, ABORT} state_t;

  state_t          state;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;
  logic            pick_valid;
  logic [CW-1:0]   wd_cnt;
  logic [DW-1:0]   addr_a  [NREQ];
  logic [DW-1:0]   wdata_a [NREQ];
  logic            unused_penable;

  // Requester enables carry no information for arbitration.
  assign unused_penable = ^REQ_PENABLE;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i]  = REQ_PADDR[DW*i +: DW];
      wdata_a[i] = REQ_PWDATA[DW*i +: DW];
    end
  end

  // First pending requester after the previous owner, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(last_grant) + k) % NREQ);
      if (!pick_valid && REQ_PSEL[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
    if (!PRESETN_PM) begin
      state       <= IDLE;
      last_grant  <= IW'(NREQ - 1);
      gnt_idx     <= '0;
      wd_cnt      <= '0;
      REQ_PRDATA  <= '0;
      REQ_PREADY  <= '0;
      REQ_PSLVERR <= '0;
      PADDR_PM    <= '0;
      PWRITE_PM   <= 1'b0;
      PENABLE_PM  <= 1'b0;
      PWDATA_PM   <= '0;
      GRANT       <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      REQ_PREADY  <= '0;
      REQ_PSLVERR <= '0;
      TIMEOUT_ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            PADDR_PM  <= addr_a[pick_idx];
            PWDATA_PM <= wdata_a[pick_idx];
            PWRITE_PM <= REQ_PWRITE[pick_idx];
            GRANT     <= NREQ'(1) << pick_idx;
            gnt_idx   <= pick_idx;
            state     <= SETUP;
          end
        end
        SETUP: begin
          PENABLE_PM <= 1'b1;
          wd_cnt     <= '0;
          state      <= ACCESS;
        end
        ACCESS: begin
          if (PREADY_PM) begin
            REQ_PRDATA  <= PRDATA_PM;
            REQ_PREADY  <= GRANT;
            REQ_PSLVERR <= PSLVERR_PM ? GRANT : '0;
            PENABLE_PM  <= 1'b0;
            PADDR_PM    <= '0;
            PWDATA_PM   <= '0;
            PWRITE_PM   <= 1'b0;
            GRANT       <= '0;
            state       <= DONE;
          end else if (TIMEOUT != 16'd0 && wd_cnt == TIMEOUT - 16'd1) begin
            REQ_PRDATA  <= '0;
            REQ_PREADY  <= GRANT;
            REQ_PSLVERR <= GRANT;
            TIMEOUT_ERR <= 1'b1;
            PENABLE_PM  <= 1'b0;
            PADDR_PM    <= '0;
            PWDATA_PM   <= '0;
            PWRITE_PM   <= 1'b0;
            GRANT       <= '0;
            state       <= ABORT;
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        DONE: begin
          last_grant <= gnt_idx;
          state      <= IDLE;
        end
        ABORT: begin
          // Swallow the stuck bridge's late completion before granting again.
          last_grant <= gnt_idx;
          if (PREADY_PM) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bfm_apb_master_arbiter.sv
// Directed bench for bfm_apb_master_arbiter: requester drivers, a bridge responder
// and a response monitor fed from expectation queues.
module tb_bfm_apb_master_arbiter;

  localparam int unsigned NREQ = 3;
  localparam logic [15:0] TMO  = 16'd8;

  logic                 PCLK_PM;
  logic                 PRESETN_PM;
  logic [NREQ-1:0]      REQ_PSEL;
  logic [NREQ-1:0]      REQ_PENABLE;
  logic [NREQ-1:0]      REQ_PWRITE;
  logic [32*NREQ-1:0]   REQ_PADDR;
  logic [32*NREQ-1:0]   REQ_PWDATA;
  logic [31:0]          REQ_PRDATA;
  logic [NREQ-1:0]      REQ_PREADY;
  logic [NREQ-1:0]      REQ_PSLVERR;
  logic [31:0]          PADDR_PM;
  logic                 PWRITE_PM;
  logic                 PENABLE_PM;
  logic [31:0]          PWDATA_PM;
  logic [31:0]          PRDATA_PM;
  logic                 PREADY_PM;
  logic                 PSLVERR_PM;
  logic [NREQ-1:0]      GRANT;
  logic                 TIMEOUT_ERR;

  bfm_apb_master_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .PCLK_PM(PCLK_PM), .PRESETN_PM(PRESETN_PM),
    .REQ_PSEL(REQ_PSEL), .REQ_PENABLE(REQ_PENABLE), .REQ_PWRITE(REQ_PWRITE),
    .REQ_PADDR(REQ_PADDR), .REQ_PWDATA(REQ_PWDATA), .REQ_PRDATA(REQ_PRDATA),
    .REQ_PREADY(REQ_PREADY), .REQ_PSLVERR(REQ_PSLVERR),
    .PADDR_PM(PADDR_PM), .PWRITE_PM(PWRITE_PM), .PENABLE_PM(PENABLE_PM),
    .PWDATA_PM(PWDATA_PM), .PRDATA_PM(PRDATA_PM), .PREADY_PM(PREADY_PM),
    .PSLVERR_PM(PSLVERR_PM), .GRANT(GRANT), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
  } xfer_t;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          lat;
  } resp_t;

  xfer_t rq [NREQ][$];
  xfer_t pm_q [$];
  resp_t exp_q [$];

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          issue_cyc [NREQ];
  logic [NREQ-1:0] busy;
  xfer_t       drv;
  xfer_t       pmx;
  resp_t       rsp;

  // Bridge behaviour knobs: respond in the br_delay-th ACCESS cycle (0 = never).
  int          br_delay = 0;
  logic [31:0] br_rdata = '0;
  logic        br_err = 1'b0;
  logic        late_req = 1'b0;
  logic        late_served;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic issue(input int idx, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic write, input logic [31:0] rdata, input logic err,
                       input logic to, input int lat, input bit expect_resp);
    xfer_t x;
    resp_t r;
    x = '{idx, addr, wdata, write};
    rq[idx].push_back(x);
    pm_q.push_back(x);
    if (expect_resp) begin
      r = '{idx, rdata, err, to, lat};
      exp_q.push_back(r);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pm_q.size() != 0) && n < budget) begin
      @(negedge PCLK_PM);
      n++;
    end
    n_chk++;
    if (exp_q.size() != 0 || pm_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: timed out with %0d responses and %0d transfers outstanding, expected 0",
               name, exp_q.size(), pm_q.size());
      exp_q.delete();
      pm_q.delete();
    end
  endtask

  initial begin
    PCLK_PM = 1'b0;
    forever #5 PCLK_PM = ~PCLK_PM;
  end

  initial forever begin
    @(posedge PCLK_PM);
    cyc++;
  end

  // Requesters: hold PSEL and payload until REQ_PREADY, then take the next queued transfer.
  initial begin
    REQ_PSEL = '0; REQ_PENABLE = '0; REQ_PWRITE = '0;
    REQ_PADDR = '0; REQ_PWDATA = '0; busy = '0;
    forever begin
      @(posedge PCLK_PM);
      #1;
      if (!PRESETN_PM) begin
        busy = '0;
        REQ_PSEL = '0;
        REQ_PENABLE = '0;
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (busy[i]) begin
            if (REQ_PREADY[i]) begin
              busy[i] = 1'b0;
              REQ_PSEL[i] = 1'b0;
              REQ_PENABLE[i] = 1'b0;
            end
          end else if (rq[i].size() != 0) begin
            drv = rq[i].pop_front();
            REQ_PSEL[i] = 1'b1;
            REQ_PENABLE[i] = 1'b1;
            REQ_PWRITE[i] = drv.write;
            REQ_PADDR[32*i +: 32] = drv.addr;
            REQ_PWDATA[32*i +: 32] = drv.wdata;
            issue_cyc[i] = cyc;
            busy[i] = 1'b1;
          end
        end
      end
    end
  end

  // Bridge responder: checks each granted transfer and enforces the PENABLE gap.
  initial begin
    int acc;
    int low;
    bit first;
    acc = 0; low = 0; first = 1'b1;
    late_served = 1'b0;
    PREADY_PM = 1'b0; PSLVERR_PM = 1'b0; PRDATA_PM = '0;
    forever begin
      @(negedge PCLK_PM);
      PREADY_PM = 1'b0; PSLVERR_PM = 1'b0; PRDATA_PM = '0;
      if (!PRESETN_PM) begin
        acc = 0; low = 0; first = 1'b1;
      end else if (PENABLE_PM) begin
        if (acc == 0) begin
          if (!first) begin
            n_chk++;
            if (low < 3) begin
              n_fail++;
              $display("FAIL penable_gap: %0d low cycles, required at least 3", low);
            end
          end
          first = 1'b0;
          if (pm_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL pm_transfer: got unexpected transfer addr 0x%08h, expected none", PADDR_PM);
          end else begin
            pmx = pm_q.pop_front();
            chk("pm_grant", 32'(GRANT), 32'(1) << pmx.idx);
            chk("pm_addr", PADDR_PM, pmx.addr);
            chk("pm_wdata", PWDATA_PM, pmx.wdata);
            chk("pm_write", 32'(PWRITE_PM), 32'(pmx.write));
          end
        end
        acc++;
        if (br_delay != 0 && acc == br_delay) begin
          PREADY_PM = 1'b1;
          PRDATA_PM = br_rdata;
          PSLVERR_PM = br_err;
        end
      end else begin
        if (acc != 0) low = 0;
        acc = 0;
        low++;
        if (late_req && !late_served) begin
          PREADY_PM = 1'b1;
          PRDATA_PM = 32'hDEAD_BEEF;
          PSLVERR_PM = 1'b1;
          late_served = 1'b1;
        end
      end
    end
  end

  // Response monitor.
  initial forever begin
    @(negedge PCLK_PM);
    if (PRESETN_PM) begin
      if (REQ_PREADY != '0) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL resp_unexpected: got REQ_PREADY 0x%0h, expected no response", REQ_PREADY);
        end else begin
          rsp = exp_q.pop_front();
          chk("resp_ready", 32'(REQ_PREADY), 32'(1) << rsp.idx);
          chk("resp_slverr", 32'(REQ_PSLVERR), rsp.err ? (32'(1) << rsp.idx) : 32'(0));
          chk("resp_prdata", REQ_PRDATA, rsp.rdata);
          chk("resp_timeout_err", 32'(TIMEOUT_ERR), 32'(rsp.to));
          if (rsp.lat != 0) chk("resp_latency", 32'(cyc - issue_cyc[rsp.idx]), 32'(rsp.lat));
        end
      end else if (REQ_PSLVERR != '0 || TIMEOUT_ERR) begin
        n_chk++; n_fail++;
        $display("FAIL stray_flags: got PSLVERR 0x%0h TIMEOUT_ERR %0b without REQ_PREADY, expected 0",
                 REQ_PSLVERR, TIMEOUT_ERR);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    PRESETN_PM = 1'b0;
    repeat (3) @(negedge PCLK_PM);
    chk("reset_grant", 32'(GRANT), 32'(0));
    chk("reset_penable", 32'(PENABLE_PM), 32'(0));
    chk("reset_paddr", PADDR_PM, 32'(0));
    chk("reset_ready", 32'(REQ_PREADY), 32'(0));
    chk("reset_prdata", REQ_PRDATA, 32'(0));
    chk("reset_timeout_err", 32'(TIMEOUT_ERR), 32'(0));
    PRESETN_PM = 1'b1;
    repeat (2) @(negedge PCLK_PM);

    // Single write from requester 1, bridge answers in the 5th ACCESS cycle.
    br_delay = 5; br_rdata = 32'h0000_0000; br_err = 1'b0;
    issue(1, 32'h1000_0040, 32'hA5A5_0001, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 7, 1'b1);
    wait_done("single_write", 100);
    repeat (2) @(negedge PCLK_PM);

    // Read from requester 0 with a bridge error.
    br_delay = 1; br_rdata = 32'hCAFE_F00D; br_err = 1'b1;
    issue(0, 32'h2000_0010, 32'h0000_0000, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, 3, 1'b1);
    wait_done("read_err", 100);
    repeat (2) @(negedge PCLK_PM);

    // Watchdog abort on requester 2; requester 0 waits for the discarded late PREADY.
    br_delay = 0; br_rdata = 32'h0000_0000; br_err = 1'b0;
    issue(2, 32'h3000_0000, 32'h0000_0033, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 10, 1'b1);
    wait_done("watchdog", 100);
    issue(0, 32'h4000_0004, 32'h0000_0000, 1'b0, 32'h4444_0000, 1'b0, 1'b0, 0, 1'b1);
    repeat (5) @(negedge PCLK_PM);
    chk("abort_no_grant", 32'(GRANT), 32'(0));
    chk("abort_penable", 32'(PENABLE_PM), 32'(0));
    br_delay = 2; br_rdata = 32'h4444_0000; br_err = 1'b0;
    late_req = 1'b1;
    for (int n = 0; n < 10 && !late_served; n++) @(negedge PCLK_PM);
    @(negedge PCLK_PM);
    chk("prdata_after_discard", REQ_PRDATA, 32'(0));
    wait_done("after_abort", 100);
    repeat (2) @(negedge PCLK_PM);

    // PREADY lands on the 8th ACCESS cycle: normal completion wins.
    br_delay = 8; br_rdata = 32'h0000_5A5A; br_err = 1'b0;
    issue(1, 32'h5000_0008, 32'h5555_AAAA, 1'b1, 32'h0000_5A5A, 1'b0, 1'b0, 10, 1'b1);
    wait_done("race", 100);
    repeat (2) @(negedge PCLK_PM);

    // Reset during ACCESS, then three requesters contend.
    br_delay = 0;
    issue(2, 32'h6000_0000, 32'h0000_0066, 1'b1, 32'h0, 1'b0, 1'b0, 0, 1'b0);
    for (int n = 0; n < 20 && !PENABLE_PM; n++) @(negedge PCLK_PM);
    chk("midreset_in_access", 32'(PENABLE_PM), 32'(1));
    repeat (2) @(negedge PCLK_PM);
    PRESETN_PM = 1'b0;
    #1;
    chk("midreset_penable", 32'(PENABLE_PM), 32'(0));
    chk("midreset_grant", 32'(GRANT), 32'(0));
    chk("midreset_paddr", PADDR_PM, 32'(0));
    chk("midreset_pwdata", PWDATA_PM, 32'(0));
    chk("midreset_pwrite", 32'(PWRITE_PM), 32'(0));
    chk("midreset_prdata", REQ_PRDATA, 32'(0));
    chk("midreset_ready", 32'(REQ_PREADY), 32'(0));
    br_delay = 2; br_rdata = 32'h0F0F_0000; br_err = 1'b0;
    for (int k = 0; k < 6; k++)
      issue(k % 3, 32'h7000_0000 + 32'(k * 16), 32'(k), 1'(k % 2), 32'h0F0F_0000, 1'b0, 1'b0, 0, 1'b1);
    repeat (2) @(negedge PCLK_PM);
    PRESETN_PM = 1'b1;
    wait_done("fairness", 400);
    repeat (3) @(negedge PCLK_PM);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bfm_apb_master_arbiter.md
Name: bfm_apb_master_arbiter

Overview:
- Shares the single master-side APB port of the APB-to-APB bridge between NREQ APB requesters, such as BFM masters or a test sequencer.
- Each requester sees an APB completer interface; the arbiter replays the granted transfer on the bridge's PM port.
- Arbitration is round-robin; one transfer is outstanding at a time.
- A watchdog bounds how long any requester can wait for the bridge.

Parameters:
- NREQ, 2: number of requesters; legal range 2..4.
- TIMEOUT, 16'd1024: ACCESS cycles without PREADY_PM before a forced error response; 0 disables the watchdog.

Ports:
- PCLK_PM  in  1  clock; also clocks the bridge PM side.
- PRESETN_PM  in  1  reset, asynchronous, active-low.
- REQ_PSEL  in  NREQ  per-requester select; high means a request is pending.
- REQ_PENABLE  in  NREQ  per-requester enable; ignored for arbitration.
- REQ_PWRITE  in  NREQ  per-requester write flag.
- REQ_PADDR  in  32*NREQ  requester i uses bits [32i+31:32i].
- REQ_PWDATA  in  32*NREQ  packed the same way as REQ_PADDR.
- REQ_PRDATA  out  32  read data, shared by all requesters; valid with REQ_PREADY.
- REQ_PREADY  out  NREQ  one-cycle completion pulse to the granted requester.
- REQ_PSLVERR  out  NREQ  error flag, valid with REQ_PREADY.
- PADDR_PM  out  32  address to the bridge.
- PWRITE_PM  out  1  write flag to the bridge.
- PENABLE_PM  out  1  enable to the bridge.
- PWDATA_PM  out  32  write data to the bridge.
- PRDATA_PM  in  32  read data from the bridge.
- PREADY_PM  in  1  bridge completion; a one-cycle pulse.
- PSLVERR_PM  in  1  bridge error flag.
- GRANT  out  NREQ  one-hot owner of the current transfer.
- TIMEOUT_ERR  out  1  one-cycle pulse on a watchdog abort.

Behaviour:
- Reset: all outputs are 0; FSM is IDLE; last_grant = NREQ-1, so requester 0 wins first; watchdog count = 0.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, DONE, ABORT.
- IDLE:
  - PM outputs are all 0.
  - If any REQ_PSEL bit is high, select the first set bit scanning from last_grant+1, wrapping mod NREQ.
  - Latch that requester's PADDR, PWDATA and PWRITE; set GRANT one-hot; go to SETUP.
- SETUP:
  - Drive the latched PADDR_PM, PWDATA_PM and PWRITE_PM with PENABLE_PM = 0.
  - Clear the watchdog; go to ACCESS next cycle.
- ACCESS:
  - PENABLE_PM = 1; address, data and write are held stable.
  - If PREADY_PM = 1:
    - Register REQ_PRDATA <= PRDATA_PM, REQ_PREADY[g] <= 1, REQ_PSLVERR[g] <= PSLVERR_PM.
    - Drop PENABLE_PM; go to DONE.
  - Else, if TIMEOUT != 0 and this is the TIMEOUT-th consecutive ACCESS cycle:
    - Respond REQ_PREADY[g] = 1, REQ_PSLVERR[g] = 1, REQ_PRDATA = 0.
    - Pulse TIMEOUT_ERR; drop PENABLE_PM; go to ABORT.
  - Else increment the watchdog; the count saturates and never wraps.
  - PREADY_PM and the timeout in the same cycle: PREADY_PM wins and no error is flagged.
- DONE (1 cycle):
  - PENABLE_PM = 0; PADDR_PM, PWDATA_PM and PWRITE_PM return to 0; GRANT = 0.
  - last_grant <= g; go to IDLE.
  - This guarantees at least 3 low cycles of PENABLE_PM between transfers, which the bridge needs to see a fresh PENABLE rising edge.
- ABORT:
  - PM outputs are 0; GRANT = 0; last_grant <= g; no new grant is issued.
  - Wait for the late PREADY_PM from the stuck bridge, discard it, then go to IDLE. This prevents a stale completion being credited to the next transfer.
- REQ_PREADY and REQ_PSLVERR are 0 in every cycle except the response cycle.
- REQ_PRDATA holds its last value between responses.
- Latency: request visible in IDLE at cycle 0 → SETUP at 1 → PENABLE_PM high at 2 → PREADY_PM at cycle k → REQ_PREADY at k+1.
- Requester rules:
  - A requester holds PSEL and its payload until its REQ_PREADY.
  - A REQ_PSEL still high in the IDLE cycle after DONE is treated as a new transfer.
  - A requester deasserting PSEL before its grant is simply not selected; no error.
- Reset mid-transfer: all state clears immediately and no response is given. The bridge shares PRESETN_PM and clears with it.

Test Plan:
- Single write: REQ1 writes 0x1000_0040/0xA5A5_0001; bridge returns PREADY_PM at cycle 6 → PENABLE_PM high at cycles 2–6; REQ_PREADY[1] at cycle 7 with REQ_PSLVERR[1] = 0.
- Read: REQ0 reads and the bridge returns PRDATA_PM = 0xCAFE_F00D with PSLVERR_PM = 1 → REQ_PRDATA = 0xCAFE_F00D and REQ_PSLVERR[0] = 1 in the same cycle; other bits of REQ_PREADY stay 0.
- Fairness: NREQ = 3, all requesters continuously requesting for 6 transfers → grant order 0,1,2,0,1,2; PENABLE_PM is low for at least 3 cycles between transfers.
- Watchdog: TIMEOUT = 8 and the bridge never responds → TIMEOUT_ERR and REQ_PREADY[g] pulse after the 8th ACCESS cycle with REQ_PSLVERR = 1 and REQ_PRDATA = 0. REQ0 pending meanwhile is not granted until the late PREADY_PM arrives and is discarded.
- Race: PREADY_PM lands exactly on the TIMEOUT-th ACCESS cycle → normal response; TIMEOUT_ERR stays 0.
- Reset: PRESETN_PM pulsed low during ACCESS → all outputs are 0 the same cycle; after release, requester 0 wins first.
